dot_product_sequencer: RTL

//  Upstream controller for one MAC lane. Accepts a dot-product job of LEN element pairs
//  and pulses MAC clear before the first pair. Streams (data, weight) FP32 pairs into the
//  MAC one per cycle, then captures the MAC accumulator as the job result.
//  The result is presented on a valid/ready port for the downstream result buffer.

---
 rtl/dot_product_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dot_product_sequencer.sv
// Purpose: feeds one MAC lane with a job of len (data, weight) pairs, then captures the accumulator as the result.
// Latency: res_valid rises two edges after the edge that accepts the last pair (or the start edge for len=0).
// Backpressure: in_ready only in FEED (one pair per cycle); the result is held in HOLD until res_ready.
module dot_product_sequencer #(
    parameter int DW    = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic [DW-1:0]    in_data,
    input  logic             in_data_valid,
    input  logic [DW-1:0]    in_weight,
    input  logic             in_weight_valid,
    output logic             in_ready,
    output logic             mac_clear,
    output logic [DW:0]      mac_data,
    output logic [DW:0]      mac_weight,
    input  logic [DW-1:0]    mac_out,
    output logic [DW-1:0]    res_value,
    output logic             res_valid,
    input  logic             res_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [DW-1:0]    dat_val_q, dat_val_d;
    logic [DW-1:0]    wgt_val_q, wgt_val_d;
    logic             pair_vld_q, pair_vld_d;
    logic [DW-1:0]    res_value_q, res_value_d;
    logic             res_valid_q, res_valid_d;
    logic             accept;

    // A pair is taken only while feeding and only when both operands are present.
    assign accept = (state_q == S_FEED) && in_data_valid && in_weight_valid;

    // Every output is a flop or a pure decode of the state register.
    assign busy       = (state_q != S_IDLE);
    assign in_ready   = (state_q == S_FEED);
    assign mac_clear  = (state_q == S_CLEAR);
    assign mac_data   = {dat_val_q, pair_vld_q};
    assign mac_weight = {wgt_val_q, pair_vld_q};
    assign res_value  = res_value_q;
    assign res_valid  = res_valid_q;

    // Next-state and datapath decisions; operand values hold when no pair is accepted.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        dat_val_d   = dat_val_q;
        wgt_val_d   = wgt_val_q;
        pair_vld_d  = 1'b0;
        res_value_d = res_value_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    count_d = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (len_q == '0) ? S_CAPTURE : S_FEED;
            end
            S_FEED: begin
                if (accept) begin
                    dat_val_d  = in_data;
                    wgt_val_d  = in_weight;
                    pair_vld_d = 1'b1;
                    count_d    = count_q + LEN_W'(1);
                    if (count_q == len_q - LEN_W'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The last pair entered the MAC on the previous edge, so mac_out is final here.
                res_value_d = mac_out;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            count_q     <= '0;
            dat_val_q   <= '0;
            wgt_val_q   <= '0;
            pair_vld_q  <= 1'b0;
            res_value_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            dat_val_q   <= dat_val_d;
            wgt_val_q   <= wgt_val_d;
            pair_vld_q  <= pair_vld_d;
            res_value_q <= res_value_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule
